// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester byte streams, the UART start/done handshake and the
// grant status of the UART TX arbiter.
//   master : the surroundings (requesters + UART TX FSM) -- drives req_* and
//            tx_busy/tx_done, observes grants and the UART-side byte.
//   slave  : the arbiter itself.
// Signals:
//   req_valid[NUM_REQ]    per-requester byte valid
//   req_data[8*NUM_REQ]   per-requester byte, slice i is [8i+7:8i]
//   req_last[NUM_REQ]     final byte of a packet, sampled with the byte
//   req_ready[NUM_REQ]    per-requester accept
//   tx_start              one-cycle frame start pulse to the UART
//   tx_data[8]            byte for the UART, held until tx_done
//   tx_busy               UART frame in progress
//   tx_done               one-cycle pulse at the end of the stop bit
//   grant_active          a requester owns the UART
//   grant_id              owner index, valid while grant_active
//   timeout_err           one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int GID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 grant_active;
    logic [GID_W-1:0]     grant_id;
    logic                 timeout_err;

    modport master (
        output req_valid, req_data, req_last, tx_busy, tx_done,
        input  req_ready, tx_start, tx_data, grant_active, grant_id, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy, tx_done,
        output req_ready, tx_start, tx_data, grant_active, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Round-robin arbitration, grant locked for a whole packet (until the byte
// flagged req_last has been sent), start/done handshake towards the UART.
// A granted requester that stalls mid-packet loses the grant after TIMEOUT
// idle cycles in FETCH (TIMEOUT=0 disables this).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_arbiter_if.slave (requesters, UART handshake, grant status)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_arbiter_if.slave    bus
);
    localparam int GID_W = $clog2(NUM_REQ);
    // The counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t             r_state;
    logic [GID_W-1:0]   r_rr_ptr;
    logic [GID_W-1:0]   r_grant_id;
    logic               r_grant_active;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic               r_timeout_err;
    logic               r_last_flag;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_fetch_open;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [7:0]         w_sel_data;
    logic               w_sel_last;
    logic               w_xfer;
    logic               w_arb_found;
    logic [GID_W-1:0]   w_arb_idx;
    logic [GID_W-1:0]   w_next_ptr;

    // FETCH withholds ready while the UART is still busy, which protects a
    // frame left running by a reset that hit the arbiter mid-frame.
    assign w_fetch_open = (r_state == FETCH) && !bus.tx_busy;

    always_comb begin
        w_req_ready = '0;
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == GID_W'(i)) begin
                w_req_ready[i] = w_fetch_open;
                w_sel_data     = bus.req_data[8*i +: 8];
                w_sel_last     = bus.req_last[i];
            end
        end
    end

    assign w_xfer = |(bus.req_valid & w_req_ready);

    // Round-robin search: first pass covers rr_ptr..NUM_REQ-1, second pass
    // the wrapped part 0..rr_ptr-1.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_arb_found && bus.req_valid[j] && (GID_W'(j) >= r_rr_ptr)) begin
                w_arb_found = 1'b1;
                w_arb_idx   = GID_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_arb_found && bus.req_valid[j] && (GID_W'(j) < r_rr_ptr)) begin
                w_arb_found = 1'b1;
                w_arb_idx   = GID_W'(j);
            end
        end
    end

    // Explicit wrap keeps rr_ptr below NUM_REQ for non-power-of-two counts.
    assign w_next_ptr = (r_grant_id == GID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + GID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_rr_ptr       <= '0;
            r_grant_id     <= '0;
            r_grant_active <= 1'b0;
            r_tx_start     <= 1'b0;
            r_tx_data      <= '0;
            r_timeout_err  <= 1'b0;
            r_last_flag    <= 1'b0;
            r_cnt          <= '0;
        end else begin
            r_tx_start    <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_arb_found) begin
                        r_grant_id     <= w_arb_idx;
                        r_grant_active <= 1'b1;
                        r_cnt          <= '0;
                        r_state        <= FETCH;
                    end
                end
                FETCH: begin
                    // A transfer always beats an expiring timeout.
                    if (w_xfer) begin
                        r_tx_data   <= w_sel_data;
                        r_last_flag <= w_sel_last;
                        r_cnt       <= '0;
                        r_state     <= SEND;
                    end else if (!bus.tx_busy) begin
                        if ((TIMEOUT != 0) && (r_cnt == CNT_MAX)) begin
                            r_timeout_err  <= 1'b1;
                            r_grant_active <= 1'b0;
                            r_rr_ptr       <= w_next_ptr;
                            r_cnt          <= '0;
                            r_state        <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                SEND: begin
                    r_tx_start <= 1'b1;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (bus.tx_done) begin
                        r_cnt <= '0;
                        if (r_last_flag) begin
                            r_grant_active <= 1'b0;
                            r_rr_ptr       <= w_next_ptr;
                            r_state        <= IDLE;
                        end else begin
                            r_state <= FETCH;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.tx_start     = r_tx_start;
    assign bus.tx_data      = r_tx_data;
    assign bus.grant_active = r_grant_active;
    assign bus.grant_id     = r_grant_id;
    assign bus.timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Bench for uart_tx_arbiter: a 4-requester instance (TIMEOUT=16) driven by a
// queue-based requester model and a UART model with 160-cycle frames, plus a
// 2-requester instance for the alternating-grant case. Expected (grant, byte)
// pairs are queued when stimulus is issued and popped on every tx_start.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    localparam int N        = 4;
    localparam int UART_LAT = 160;
    localparam int LAT2     = 20;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst2_n = 1'b0;

    initial forever #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) ifc ();
    uart_tx_arbiter_if #(.NUM_REQ(2)) ifc2 ();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT(16)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (ifc2.slave)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       last;
    } req_byte_t;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    req_byte_t  pend[$];
    exp_t       sb[$];
    exp_t       sb2[$];

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   n_starts   = 0;
    int   n_starts2  = 0;
    logic force_busy = 1'b0;
    logic dut2_done  = 1'b0;
    logic [7:0] last_start_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input int id, input logic [7:0] data, input logic last);
        req_byte_t b;
        exp_t      e;
        b.id = id; b.data = data; b.last = last;
        e.id = id; e.data = data;
        pend.push_back(b);
        sb.push_back(e);
    endtask

    function automatic int pend_count(input int id);
        int c = 0;
        foreach (pend[k]) if (pend[k].id == id) c++;
        return c;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int ok = 0;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && pend.size() == 0 && !ifc.grant_active && !ifc.tx_busy) begin
                ok = 1;
                break;
            end
        end
        check_eq(tag, ok, 1);
    endtask

    // Requester model: each requester presents its oldest pending byte;
    // a byte retires after a cycle in which valid && ready held.
    initial begin
        logic [N-1:0]   xfer, v, l;
        logic [8*N-1:0] d;
        ifc.req_valid = '0;
        ifc.req_data  = '0;
        ifc.req_last  = '0;
        forever begin
            @(negedge clk);
            xfer = ifc.req_valid & ifc.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (xfer[i]) begin
                    for (int k = 0; k < pend.size(); k++) begin
                        if (pend[k].id == i) begin
                            pend.delete(k);
                            break;
                        end
                    end
                end
            end
            v = '0; l = '0; d = '0;
            // Walk backwards so the oldest entry of each requester wins.
            for (int k = pend.size() - 1; k >= 0; k--) begin
                for (int i = 0; i < N; i++) begin
                    if (pend[k].id == i) begin
                        v[i]        = 1'b1;
                        l[i]        = pend[k].last;
                        d[8*i +: 8] = pend[k].data;
                    end
                end
            end
            ifc.req_valid = v;
            ifc.req_last  = l;
            ifc.req_data  = d;
        end
    end

    // UART model for the main instance: tx_done UART_LAT cycles after tx_start.
    initial begin
        int   cnt  = 0;
        logic busy = 1'b0;
        ifc.tx_busy = 1'b0;
        ifc.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ifc.tx_done) begin
                ifc.tx_done = 1'b0;
                busy        = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) ifc.tx_done = 1'b1;
            end
            if (ifc.tx_start && !busy) begin
                busy = 1'b1;
                cnt  = UART_LAT;
            end
            ifc.tx_busy = busy | force_busy;
        end
    end

    // UART model for the two-requester instance.
    initial begin
        int   cnt  = 0;
        logic busy = 1'b0;
        ifc2.tx_busy = 1'b0;
        ifc2.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ifc2.tx_done) begin
                ifc2.tx_done = 1'b0;
                busy         = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) ifc2.tx_done = 1'b1;
            end
            if (ifc2.tx_start && !busy) begin
                busy = 1'b1;
                cnt  = LAT2;
            end
            ifc2.tx_busy = busy;
        end
    end

    // Scoreboard monitors.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifc.tx_start) begin
                n_starts++;
                check_eq("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("tx_data", ifc.tx_data, e.data);
                    check_eq("grant_id_at_start", ifc.grant_id, e.id);
                    check_eq("grant_active_at_start", ifc.grant_active, 1);
                end
                last_start_data = ifc.tx_data;
            end
            if (ifc.tx_done) check_eq("tx_data_hold", ifc.tx_data, last_start_data);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifc2.tx_start) begin
                n_starts2++;
                check_eq("wrap_sb_has_entry", sb2.size() != 0, 1);
                if (sb2.size() != 0) begin
                    e = sb2.pop_front();
                    check_eq("wrap_grant_id", ifc2.grant_id, e.id);
                    check_eq("wrap_tx_data", ifc2.tx_data, e.data);
                end
            end
        end
    end

    // Two-requester instance: both continuously valid with 1-byte packets.
    initial begin
        exp_t e;
        ifc2.req_valid = '0;
        ifc2.req_data  = {8'hA1, 8'hA0};
        ifc2.req_last  = 2'b11;
        for (int i = 0; i < 6; i++) begin
            e.id   = i % 2;
            e.data = (i % 2 == 1) ? 8'hA1 : 8'hA0;
            sb2.push_back(e);
        end
        wait (rst2_n);
        @(posedge clk);
        #1;
        ifc2.req_valid = 2'b11;
        for (int c = 0; c < 2000 && n_starts2 < 6; c++) begin
            @(posedge clk);
            #1;
        end
        ifc2.req_valid = 2'b00;
        dut2_done = 1'b1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, starts0, first_j, pulses, ga_at, rdy_seen, rem1, got0, ok;

        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        @(negedge clk);
        check_eq("rst_grant_active", ifc.grant_active, 0);
        check_eq("rst_grant_id", ifc.grant_id, 0);
        check_eq("rst_tx_start", ifc.tx_start, 0);
        check_eq("rst_tx_data", ifc.tx_data, 0);
        check_eq("rst_timeout_err", ifc.timeout_err, 0);
        check_eq("rst_req_ready", ifc.req_ready, 0);

        // Single requester, 3-byte packet.
        push_req(0, 8'h41, 1'b0);
        push_req(0, 8'h42, 1'b0);
        push_req(0, 8'h43, 1'b1);
        nd = 0;
        for (int c = 0; c < 2000 && nd < 3; c++) begin
            @(negedge clk);
            if (ifc.tx_done) begin
                nd++;
                check_eq("single_grant_id", ifc.grant_id, 0);
                if (nd == 3) begin
                    check_eq("single_active_at_done", ifc.grant_active, 1);
                    @(negedge clk);
                    check_eq("single_active_after_done", ifc.grant_active, 0);
                end
            end
        end
        check_eq("single_dones", nd, 3);
        wait_idle("single_drain", 500);

        // Round-robin, three 1-byte packets valid together.
        do_reset();
        push_req(0, 8'h10, 1'b1);
        push_req(1, 8'h11, 1'b1);
        push_req(2, 8'h12, 1'b1);
        wait_idle("rr_drain", 2000);
        do_reset();
        push_req(0, 8'h20, 1'b1);
        push_req(2, 8'h22, 1'b1);
        wait_idle("rr2_drain", 2000);

        // Packet lock: req 0 shows up after req 1's first byte.
        do_reset();
        push_req(1, 8'hB0, 1'b0);
        push_req(1, 8'hB1, 1'b0);
        push_req(1, 8'hB2, 1'b0);
        push_req(1, 8'hB3, 1'b1);
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (pend_count(1) == 3) begin
                ok = 1;
                break;
            end
        end
        check_eq("lock_first_byte", ok, 1);
        push_req(0, 8'h50, 1'b0);
        push_req(0, 8'h51, 1'b1);
        rdy_seen = 0; got0 = 0; rem1 = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (ifc.grant_active && ifc.grant_id == 0) begin
                got0 = 1;
                rem1 = pend_count(1);
                break;
            end
            if (ifc.req_ready[0]) rdy_seen = 1;
        end
        check_eq("lock_grant0_reached", got0, 1);
        check_eq("lock_req1_remaining", rem1, 0);
        check_eq("lock_ready0_seen", rdy_seen, 0);
        wait_idle("lock_drain", 2000);

        // Timeout: req 3 sends one non-last byte and goes silent.
        do_reset();
        push_req(3, 8'h33, 1'b0);
        ok = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (ifc.tx_done) begin
                ok = 1;
                break;
            end
        end
        check_eq("to_done_seen", ok, 1);
        first_j = -1; pulses = 0; ga_at = -1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (ifc.timeout_err) begin
                pulses++;
                if (first_j < 0) begin
                    first_j = j;
                    ga_at   = ifc.grant_active;
                end
            end
        end
        // tx_done cycle is j=0, FETCH re-entry j=1, pulse 16 cycles later.
        check_eq("to_pulse_cycle", first_j, 17);
        check_eq("to_pulse_count", pulses, 1);
        check_eq("to_grant_active", ga_at, 0);
        push_req(1, 8'h61, 1'b1);
        push_req(3, 8'h63, 1'b1);
        wait_idle("to_rr_drain", 2000);

        // Busy guard: reset while the UART is busy.
        @(negedge clk);
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();
        starts0 = n_starts;
        push_req(2, 8'h5A, 1'b1);
        rdy_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ifc.req_ready[2]) rdy_seen = 1;
        end
        check_eq("guard_ready2_while_busy", rdy_seen, 0);
        check_eq("guard_grant_active", ifc.grant_active, 1);
        check_eq("guard_grant_id", ifc.grant_id, 2);
        force_busy = 1'b0;
        wait_idle("guard_drain", 1000);
        repeat (20) @(negedge clk);
        check_eq("guard_start_count", n_starts - starts0, 1);

        // Two-requester alternation.
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (dut2_done) begin
                ok = 1;
                break;
            end
        end
        check_eq("wrap_finished", ok, 1);
        repeat (60) @(negedge clk);
        check_eq("wrap_sb_empty", sb2.size(), 0);
        check_eq("wrap_start_count", n_starts2, 6);
        check_eq("wrap_grant_released", ifc2.grant_active, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
